prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_pkg.sv | 13 +
 rtl/prefetch_fifo.sv | 55 +++++
 rtl/prefetch_unit.sv | 116 +++++++++++
 tb/tb_prefetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// rtl/prefetch_pkg.sv - shared FSM encoding and fetch constants for the prefetch unit
package prefetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam int INSTR_WIDTH  = 32;
  localparam int FETCH_STRIDE = 4;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - DEPTH-entry synchronous buffer of {pc, instr} with flush
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Flush wins over any coincident push or pop.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count_q != '0);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr] <= push_data;
  end

  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr];

endmodule

// File: rtl/prefetch_unit.sv
// rtl/prefetch_unit.sv - instruction prefetcher with credit-limited issue and redirect flush
module prefetch_unit
  import prefetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DEPTH         = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = '0
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_address,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   buffer_empty
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + INSTR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_address;
  logic [ADDR_WIDTH-1:0] resp_pc;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [CW-1:0]         outstanding;
  logic [CW-1:0]         discard;
  logic [CW-1:0]         occupancy;
  logic [CW-1:0]         occ_next;
  logic [CW-1:0]         out_next;
  logic [CW-1:0]         credits_next;
  logic                  grant;
  logic                  push;
  logic                  pop;
  logic                  drop_rsp;
  logic                  fifo_empty;
  logic [EW-1:0]         head;

  assign redirect_target = redirect_address & ~ADDR_WIDTH'(3);
  assign mem_addr        = fetch_address;
  assign grant           = mem_req & mem_gnt;
  assign drop_rsp        = redirect_valid | (discard != '0);
  assign push            = mem_rvalid & ~drop_rsp;
  assign pop             = instr_valid & instr_ready & ~redirect_valid;

  // Credits are judged on next-cycle counts so RUN never issues past DEPTH.
  assign out_next     = outstanding + CW'(grant) - CW'(mem_rvalid);
  assign occ_next     = redirect_valid ? '0 : occupancy + CW'(push) - CW'(pop);
  assign credits_next = occ_next + out_next;

  always_comb begin
    state_d = state_q;
    mem_req = (state_q == RUN) && !redirect_valid;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = (credits_next == CW'(DEPTH)) ? STALL : RUN;
        RUN:     if (credits_next == CW'(DEPTH)) state_d = STALL;
        STALL:   if (credits_next < CW'(DEPTH)) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_address <= RESET_ADDRESS;
      resp_pc       <= RESET_ADDRESS;
      outstanding   <= '0;
      discard       <= '0;
    end else begin
      state_q     <= state_d;
      outstanding <= out_next;
      if (redirect_valid) begin
        fetch_address <= redirect_target;
        resp_pc       <= redirect_target;
        // A response arriving with the redirect already retires one request.
        discard       <= outstanding - CW'(mem_rvalid);
      end else begin
        if (grant) fetch_address <= fetch_address + ADDR_WIDTH'(FETCH_STRIDE);
        if (push)  resp_pc       <= resp_pc + ADDR_WIDTH'(FETCH_STRIDE);
        if (mem_rvalid && (discard != '0)) discard <= discard - CW'(1);
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({resp_pc, mem_rdata}),
    .pop       (pop),
    .head_data (head),
    .count     (occupancy),
    .empty     (fifo_empty)
  );

  assign instr_valid  = ~fifo_empty;
  assign buffer_empty = fifo_empty;
  assign instr_pc     = head[EW-1:INSTR_WIDTH];
  assign instr_data   = head[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// tb/tb_prefetch_unit.sv - directed vector bench for prefetch_unit
module tb_prefetch_unit;

  logic        CLK;
  logic        reset;
  logic        enable;
  logic        redirect_valid;
  logic [31:0] redirect_address;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        buffer_empty;

  prefetch_unit #(
    .ADDR_WIDTH    (32),
    .DEPTH         (4),
    .RESET_ADDRESS (32'h0)
  ) dut (
    .CLK              (CLK),
    .reset            (reset),
    .enable           (enable),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_data       (instr_data),
    .instr_pc         (instr_pc),
    .buffer_empty     (buffer_empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        en;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t        vt [15];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        hold;
  logic [31:0] pend [$];
  logic [31:0] grant_log [$];
  logic [31:0] got_pc [$];
  logic [31:0] got_data [$];
  logic        s_req, s_valid, s_empty;
  logic [31:0] s_addr, s_pc, s_data;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sample at negedge, then drive the memory response for the next cycle.
  task automatic run_cycle();
    logic [31:0] a;
    @(negedge CLK);
    s_req = mem_req; s_addr = mem_addr; s_valid = instr_valid;
    s_pc = instr_pc; s_data = instr_data; s_empty = buffer_empty;
    if (mem_req && mem_gnt) begin
      pend.push_back(mem_addr);
      grant_log.push_back(mem_addr);
    end
    if (instr_valid && instr_ready && !redirect_valid) begin
      got_pc.push_back(instr_pc);
      got_data.push_back(instr_data);
    end
    @(posedge CLK);
    #1;
    if (!hold && pend.size() > 0) begin
      a = pend.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = img(a);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic clear_logs();
    pend.delete(); grant_log.delete(); got_pc.delete(); got_data.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_address = '0; mem_gnt = 1'b1; hold = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    clear_logs();
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
    vt[8]  = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    vt[10] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h10};
    vt[11] = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 32'h10};
    vt[12] = '{1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h14};
    vt[13] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h14};
    vt[14] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h14};

    // Reset state, checked while reset is still asserted.
    reset = 1'b0; enable = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_address = '0; mem_gnt = 1'b1; hold = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_empty", buffer_empty, 1'b1);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    reset = 1'b1;

    // Streaming, back-pressure stall and single-pop refill.
    for (int i = 0; i < 15; i++) begin
      enable = vt[i].en;
      instr_ready = vt[i].rdy;
      run_cycle();
      chk($sformatf("row%0d_req", i), s_req, vt[i].req);
      if (vt[i].req) chk($sformatf("row%0d_addr", i), s_addr, vt[i].addr);
      chk($sformatf("row%0d_valid", i), s_valid, vt[i].valid);
      chk($sformatf("row%0d_empty", i), s_empty, !vt[i].valid);
      if (vt[i].valid) begin
        chk($sformatf("row%0d_pc", i), s_pc, vt[i].pc);
        chk($sformatf("row%0d_data", i), s_data, img(vt[i].pc));
      end
    end

    // From empty with decode stalled: exactly DEPTH grants, one pop frees one.
    do_reset();
    enable = 1'b1;
    repeat (10) run_cycle();
    chk("stall_grants", grant_log.size(), 4);
    chk("stall_req", s_req, 1'b0);
    chk("stall_head", s_pc, 32'h0);
    instr_ready = 1'b1;
    run_cycle();
    instr_ready = 1'b0;
    repeat (5) run_cycle();
    chk("refill_grants", grant_log.size(), 5);
    chk("refill_addr", qget(grant_log, 4), 32'h10);
    chk("refill_head", s_pc, 32'h4);
    chk("refill_req", s_req, 1'b0);

    // Redirect with two fetches outstanding and one buffered entry.
    do_reset();
    enable = 1'b1;
    run_cycle();
    run_cycle();
    hold = 1'b1;
    run_cycle();
    run_cycle();
    chk("rd1_pre_valid", s_valid, 1'b1);
    hold = 1'b0;
    redirect_valid = 1'b1;
    redirect_address = 32'h40;
    run_cycle();
    chk("rd1_req_blocked", s_req, 1'b0);
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    run_cycle();
    chk("rd1_addr", s_addr, 32'h40);
    chk("rd1_flushed", s_valid, 1'b0);
    repeat (6) run_cycle();
    chk("rd1_first_pc", qget(got_pc, 0), 32'h40);
    chk("rd1_first_data", qget(got_data, 0), img(32'h40));
    chk("rd1_second_pc", qget(got_pc, 1), 32'h44);

    // Unaligned redirect coincident with a response and a pop.
    do_reset();
    enable = 1'b1;
    instr_ready = 1'b1;
    repeat (4) run_cycle();
    redirect_valid = 1'b1;
    redirect_address = 32'h43;
    run_cycle();
    chk("rd2_coinc_valid", s_valid, 1'b1);
    redirect_valid = 1'b0;
    run_cycle();
    chk("rd2_addr", s_addr, 32'h40);
    chk("rd2_req", s_req, 1'b1);
    repeat (4) run_cycle();
    chk("rd2_pc0", qget(got_pc, 0), 32'h0);
    chk("rd2_pc1", qget(got_pc, 1), 32'h40);
    chk("rd2_pc2", qget(got_pc, 2), 32'h44);

    // Address wrap at the top of the space, with a withheld grant.
    do_reset();
    enable = 1'b1;
    instr_ready = 1'b1;
    run_cycle();
    redirect_valid = 1'b1;
    redirect_address = 32'hFFFF_FFFC;
    run_cycle();
    redirect_valid = 1'b0;
    mem_gnt = 1'b0;
    run_cycle();
    chk("wrap_addr_nogrant", s_addr, 32'hFFFF_FFFC);
    mem_gnt = 1'b1;
    run_cycle();
    chk("wrap_addr_stable", s_addr, 32'hFFFF_FFFC);
    run_cycle();
    chk("wrap_addr_next", s_addr, 32'h0);
    repeat (3) run_cycle();
    chk("wrap_pc0", qget(got_pc, 0), 32'hFFFF_FFFC);
    chk("wrap_data0", qget(got_data, 0), img(32'hFFFF_FFFC));
    chk("wrap_pc1", qget(got_pc, 1), 32'h0);

    // enable dropped: in-flight responses land and the buffer drains.
    do_reset();
    enable = 1'b1;
    repeat (3) run_cycle();
    enable = 1'b0;
    run_cycle();
    run_cycle();
    chk("dis_req", s_req, 1'b0);
    instr_ready = 1'b1;
    repeat (6) run_cycle();
    chk("dis_drained", got_pc.size(), 3);
    chk("dis_last_pc", qget(got_pc, 2), 32'h8);
    chk("dis_empty", s_empty, 1'b1);
    chk("dis_grants", grant_log.size(), 3);

    // Asynchronous reset with a full buffer, then restart.
    do_reset();
    enable = 1'b1;
    repeat (10) run_cycle();
    chk("ar_full", s_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_req", mem_req, 1'b0);
    chk("ar_valid", instr_valid, 1'b0);
    chk("ar_empty", buffer_empty, 1'b1);
    chk("ar_data", instr_data, 32'h0);
    chk("ar_pc", instr_pc, 32'h0);
    mem_rvalid = 1'b0;
    clear_logs();
    @(posedge CLK);
    #1;
    reset = 1'b1;
    instr_ready = 1'b1;
    repeat (6) run_cycle();
    chk("ar_restart_addr", qget(grant_log, 0), 32'h0);
    chk("ar_restart_pc", qget(got_pc, 0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
